// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - multi-cycle read/execute/write-back sequencer for a 2R/1W register file
module regfile_seq_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] raddr_a,
   output logic [ADDR_W-1:0] raddr_b,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] din,
   output logic              wren,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero,
   output logic              done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic              accept;
   logic [2:0]        op_lat;
   logic [ADDR_W-1:0] rd_lat;
   logic [ADDR_W-1:0] rs1_lat;
   logic [ADDR_W-1:0] rs2_lat;
   logic [DATA_W-1:0] imm_lat;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic [DATA_W:0]   sum_wide;

   // Register-file addresses follow the latched instruction fields, so they only move on acceptance.
   assign raddr_a = rs1_lat;
   assign raddr_b = rs2_lat;
   assign waddr   = rd_lat;
   // Write data is the registered result computed during EXEC.
   assign din     = result;

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake/write-back strobes; one state per cycle, no stalls.
   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      wren        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = ~rst;
            accept      = instr_valid & ~rst;
            if (accept) begin
               state_next = READ;
            end
         end
         READ: begin
            state_next = EXEC;
         end
         EXEC: begin
            state_next = WRITE;
         end
         WRITE: begin
            done       = 1'b1;
            wren       = (op_lat != OP_NOP);
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the instruction fields when the handshake completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_lat  <= '0;
         rd_lat  <= '0;
         rs1_lat <= '0;
         rs2_lat <= '0;
         imm_lat <= '0;
      end else if (accept) begin
         op_lat  <= opcode;
         rd_lat  <= rd;
         rs1_lat <= rs1;
         rs2_lat <= rs2;
         imm_lat <= imm;
      end
   end

   // Capture both read ports at the end of READ; any write from the previous instruction has already landed.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
      end else if (state == READ) begin
         op_a <= dout_a;
         op_b <= dout_b;
      end
   end

   // ALU: result and carry/borrow for the latched opcode; widths wrap modulo 2^DATA_W.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      sum_wide  = {1'b0, op_a} + {1'b0, op_b};
      case (op_lat)
         OP_ADD: begin
            alu_res   = sum_wide[DATA_W-1:0];
            alu_carry = sum_wide[DATA_W];
         end
         OP_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a < op_b);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_LDI: alu_res = imm_lat;
         OP_MOV: alu_res = op_a;
         default: begin
            alu_res   = result;
            alu_carry = carry;
         end
      endcase
   end

   // Result and flags update at the end of EXEC; NOP leaves all three untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b0;
      end else if (state == EXEC && op_lat != OP_NOP) begin
         result <= alu_res;
         carry  <= alu_carry;
         zero   <= (alu_res == '0);
      end
   end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - table-driven bench for regfile_seq_ctrl with a behavioural register file
module tb_regfile_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] opcode;
   logic [1:0] rd, rs1, rs2;
   logic [3:0] imm;
   logic [1:0] raddr_a, raddr_b, waddr;
   logic [3:0] dout_a, dout_b, din;
   logic       wren;
   logic [3:0] result;
   logic       carry, zero, done;

   int checks = 0;
   int errors = 0;

   logic [3:0] rf [4];

   always #5 clk = ~clk;

   // Behavioural register file: combinational reads, write at the rising edge.
   assign dout_a = rf[raddr_a];
   assign dout_b = rf[raddr_b];
   always @(posedge clk) if (wren) rf[waddr] <= din;

   regfile_seq_ctrl #(.DATA_W(4), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .dout_a(dout_a), .dout_b(dout_b),
      .waddr(waddr), .din(din), .wren(wren), .result(result),
      .carry(carry), .zero(zero), .done(done)
   );

   typedef struct {
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [3:0] imm;
      logic [3:0] exp_din;
      logic       exp_wren;
      logic       exp_carry;
      logic       exp_zero;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for ready, present one instruction, return in the READ cycle with valid dropped.
   task automatic issue(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [3:0] im);
      int waitc = 0;
      while (instr_ready !== 1'b1 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check("ready_before_issue", 8'(instr_ready), 8'd1);
      opcode = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   // From the READ cycle: strobes quiet through READ/EXEC, then check write-back, end in IDLE.
   task automatic expect_write(input string name, input logic [3:0] e_din, input logic e_wren,
                               input logic e_carry, input logic e_zero, input logic [1:0] e_waddr);
      check({name, "_read_wren"}, 8'(wren), 8'd0);
      check({name, "_read_ready"}, 8'(instr_ready), 8'd0);
      @(negedge clk);
      check({name, "_exec_wren"}, 8'(wren), 8'd0);
      check({name, "_exec_done"}, 8'(done), 8'd0);
      @(negedge clk);
      check({name, "_done"}, 8'(done), 8'd1);
      check({name, "_wren"}, 8'(wren), 8'(e_wren));
      check({name, "_din"}, 8'(din), 8'(e_din));
      check({name, "_result"}, 8'(result), 8'(e_din));
      check({name, "_carry"}, 8'(carry), 8'(e_carry));
      check({name, "_zero"}, 8'(zero), 8'(e_zero));
      if (e_wren) check({name, "_waddr"}, 8'(waddr), 8'(e_waddr));
      @(negedge clk);
      check({name, "_idle_done"}, 8'(done), 8'd0);
   endtask

   int wren_count;
   always @(posedge clk) if (wren) wren_count <= wren_count + 1;

   initial begin
      //          op    rd    rs1   rs2   imm    din   w     c     z
      vecs[0]  = '{3'd5, 2'd0, 2'd0, 2'd0, 4'h9, 4'h9, 1'b1, 1'b0, 1'b0}; // LDI r0,9
      vecs[1]  = '{3'd5, 2'd1, 2'd0, 2'd0, 4'h8, 4'h8, 1'b1, 1'b0, 1'b0}; // LDI r1,8
      vecs[2]  = '{3'd0, 2'd2, 2'd0, 2'd1, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0}; // ADD r2=9+8
      vecs[3]  = '{3'd1, 2'd3, 2'd1, 2'd0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0}; // SUB r3=8-9
      vecs[4]  = '{3'd1, 2'd3, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1}; // SUB r3=9-9
      vecs[5]  = '{3'd2, 2'd3, 2'd0, 2'd1, 4'h0, 4'h8, 1'b1, 1'b0, 1'b0}; // AND
      vecs[6]  = '{3'd3, 2'd3, 2'd0, 2'd1, 4'h0, 4'h9, 1'b1, 1'b0, 1'b0}; // OR
      vecs[7]  = '{3'd4, 2'd3, 2'd0, 2'd1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0}; // XOR
      vecs[8]  = '{3'd6, 2'd3, 2'd1, 2'd0, 4'h0, 4'h8, 1'b1, 1'b0, 1'b0}; // MOV r3=r1
      vecs[9]  = '{3'd0, 2'd3, 2'd1, 2'd1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1}; // ADD 8+8 wraps
      vecs[10] = '{3'd7, 2'd1, 2'd0, 2'd0, 4'h5, 4'h0, 1'b0, 1'b1, 1'b1}; // NOP holds flags
      vecs[11] = '{3'd0, 2'd2, 2'd2, 2'd2, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0}; // ADD r2,r2,r2
      vecs[12] = '{3'd5, 2'd3, 2'd0, 2'd0, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0}; // LDI r3,6

      rst = 1'b1; instr_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      wren_count = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", 8'(instr_ready), 8'd0);
      check("rst_wren", 8'(wren), 8'd0);
      check("rst_done", 8'(done), 8'd0);
      check("rst_result", 8'(result), 8'd0);
      check("rst_carry", 8'(carry), 8'd0);
      check("rst_zero", 8'(zero), 8'd0);
      check("rst_raddr_a", 8'(raddr_a), 8'd0);
      check("rst_raddr_b", 8'(raddr_b), 8'd0);
      check("rst_waddr", 8'(waddr), 8'd0);
      check("rst_din", 8'(din), 8'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 8'(instr_ready), 8'd1);

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         expect_write($sformatf("v%0d", i), vecs[i].exp_din, vecs[i].exp_wren,
                      vecs[i].exp_carry, vecs[i].exp_zero, vecs[i].rd);
      end
      check("wren_pulses_table", 8'(wren_count), 8'd12);

      // Back-to-back with valid held high: LDI r2,3 then XOR r2,r2,r0 sees the new r2.
      opcode = 3'd5; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd0; imm = 4'h3;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      opcode = 3'd4; rd = 2'd2; rs1 = 2'd2; rs2 = 2'd0; imm = 4'h0;
      check("b2b_read_ready", 8'(instr_ready), 8'd0);
      @(negedge clk);
      check("b2b_exec_ready", 8'(instr_ready), 8'd0);
      @(negedge clk);
      check("b2b_ldi_ready", 8'(instr_ready), 8'd0);
      check("b2b_ldi_din", 8'(din), 8'h3);
      check("b2b_ldi_wren", 8'(wren), 8'd1);
      check("b2b_ldi_waddr", 8'(waddr), 8'd2);
      @(negedge clk);
      check("b2b_idle_ready", 8'(instr_ready), 8'd1);
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      expect_write("b2b_xor", 4'hA, 1'b1, 1'b0, 1'b0, 2'd2);

      // Reset during EXEC of ADD r3,r0,r1: no write, state cleared, r3 keeps 6.
      issue(3'd0, 2'd3, 2'd0, 2'd1, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_wren", 8'(wren), 8'd0);
      check("mid_rst_done", 8'(done), 8'd0);
      check("mid_rst_result", 8'(result), 8'd0);
      check("mid_rst_carry", 8'(carry), 8'd0);
      check("mid_rst_ready", 8'(instr_ready), 8'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_no_write", 8'(wren_count), 8'd14);
      issue(3'd6, 2'd3, 2'd3, 2'd0, 4'h0);
      expect_write("readback_mov", 4'h6, 1'b1, 1'b0, 1'b0, 2'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global bound so a stuck handshake cannot hang the run.
   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
